// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_disp_pkg
//  Description : Shared types and constants for the hex display arbiter:
//                arbiter state encoding, message/character widths, the idle
//                message and a helper that slices one message from the
//                flattened requester bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_disp_pkg;

  localparam int MSG_W   = 32;   // four ASCII characters per message
  localparam int CHAR_W  = 8;    // one ASCII character
  localparam int MAX_REQ = 8;    // widest supported requester count
  localparam int IDX_W   = 3;    // requester index width (covers MAX_REQ)

  // "Finc"
  localparam logic [MSG_W-1:0] IDLE_MSG_DEFAULT = 32'h46696E63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,  // minimum display time running
    ST_OPEN = 2'd2   // hold expired, owner retained until someone else asks
  } arb_state_t;

  // Message i from a flat bus padded out to MAX_REQ entries.
  function automatic logic [MSG_W-1:0] msg_at(
    input logic [MAX_REQ*MSG_W-1:0] flat,
    input logic [IDX_W-1:0]         idx
  );
    return flat[int'(idx)*MSG_W +: MSG_W];
  endfunction

endpackage : hex_disp_pkg
`default_nettype wire

// File: rtl/hex_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_arbiter_if
//  Description : Requester-side and display-side signals of the hex display
//                arbiter.
//                  req     : per-requester level request
//                  msg_in  : flattened messages, requester i at [i*32 +: 32]
//                  gnt     : one-hot grant (zero when idle)
//                  owner   : index of current owner (zero when idle)
//                  msg_out : registered ASCII message, digit 3 in [31:24]
//                  busy    : arbiter holding a grant
//                  done    : one-cycle pulse when a grant ends
//                Modports: master = requesters/consumer, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hex_display_arbiter_if
  import hex_disp_pkg::*;
#(
  parameter int N = 4
) ();

  logic [N-1:0]       req;
  logic [N*MSG_W-1:0] msg_in;
  logic [N-1:0]       gnt;
  logic [IDX_W-1:0]   owner;
  logic [MSG_W-1:0]   msg_out;
  logic               busy;
  logic               done;

  modport master (
    output req, msg_in,
    input  gnt, owner, msg_out, busy, done
  );

  modport slave (
    input  req, msg_in,
    output gnt, owner, msg_out, busy, done
  );

endinterface : hex_display_arbiter_if
`default_nettype wire

// File: rtl/hex_display_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches i_req starting at
//                i_ptr, wrapping modulo N, and returns the first set request.
//                  i_req   : request mask (N)
//                  i_ptr   : search start index, must be < N
//                  o_gnt   : one-hot winner (N), zero if none
//                  o_idx   : winner index, zero if none
//                  o_valid : any request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import hex_disp_pkg::*;
#(
  parameter int N = 4
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [IDX_W-1:0] i_ptr,
  output logic      [N-1:0]     o_gnt,
  output logic      [IDX_W-1:0] o_idx,
  output logic                  o_valid
);

  // Rotate right by the pointer so bit 0 of w_rot is the first candidate.
  logic [N-1:0] w_rot;
  int           w_sum;

  always_comb begin
    w_rot   = N'({i_req, i_req} >> i_ptr);
    w_sum   = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        w_sum   = int'(i_ptr) + k;
        if (w_sum >= N) begin
          w_sum = w_sum - N;
        end
        o_idx = IDX_W'(w_sum);
        o_gnt = N'(1) << o_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_arbiter
//  Description : Round-robin owner of the four-digit seven-segment message
//                path. A granted message stays on the display for at least
//                HOLD_CYCLES cycles; afterwards the owner keeps the display
//                (with live text updates) until another requester asks or it
//                lets go. With no owner the fixed IDLE_MSG is shown.
//                Ports:
//                  clk   : system clock
//                  reset : asynchronous, active-high reset
//                  bus   : hex_display_arbiter_if.slave (req, msg_in in;
//                          gnt, owner, msg_out, busy, done out, all registered)
//                Build option:
//                  HEX_ARB_PREEMPT_EN - requester 0 is an urgent channel that
//                  takes the display immediately, cutting any hold short,
//                  without moving the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int               N           = 4,
  parameter int               HOLD_CYCLES = 50_000_000,
  parameter logic [MSG_W-1:0] IDLE_MSG    = IDLE_MSG_DEFAULT
) (
  input wire logic            clk,
  input wire logic            reset,
  hex_display_arbiter_if.slave bus
);

  localparam int                 c_cnt_w     = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(N - 1);

  arb_state_t         r_state;
  logic [N-1:0]       r_gnt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [MSG_W-1:0]   r_msg;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [MAX_REQ*MSG_W-1:0] w_flat;
  logic [N-1:0]             w_pick_mask;
  logic [N-1:0]             w_pick_gnt;
  logic [IDX_W-1:0]         w_pick_idx;
  logic                     w_pick_valid;
  logic                     w_owner_req;
  logic                     w_regrant;
  logic                     w_preempt;

  always_comb begin
    w_flat                = '0;
    w_flat[N*MSG_W-1:0]   = bus.msg_in;
  end

  // r_gnt is zero in IDLE, so masking out the owner serves both the idle
  // grant and the OPEN regrant with a single picker.
  assign w_pick_mask = bus.req & ~r_gnt;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .i_req   (w_pick_mask),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_owner_req = |(bus.req & r_gnt);
  // Grants are only considered outside the minimum hold window.
  assign w_regrant   = w_pick_valid && (r_state != ST_HOLD);

`ifdef HEX_ARB_PREEMPT_EN
  assign w_preempt = (r_state != ST_IDLE) && !r_gnt[0] && bus.req[0];
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_msg   <= IDLE_MSG;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_preempt) begin
        // Urgent takeover; the round-robin pointer is deliberately untouched.
        r_state <= ST_HOLD;
        r_gnt   <= N'(1);
        r_owner <= '0;
        r_msg   <= msg_at(w_flat, IDX_W'(0));
        r_cnt   <= c_hold_load;
        r_busy  <= 1'b1;
        r_done  <= 1'b1;
      end else if (w_regrant) begin
        r_state <= ST_HOLD;
        r_gnt   <= w_pick_gnt;
        r_owner <= w_pick_idx;
        r_msg   <= msg_at(w_flat, w_pick_idx);
        r_cnt   <= c_hold_load;
        r_busy  <= 1'b1;
        r_ptr   <= (w_pick_idx == c_last_idx) ? '0 : w_pick_idx + 1'b1;
        // A fresh grant out of IDLE ends nobody's turn.
        r_done  <= (r_state == ST_OPEN);
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_msg <= IDLE_MSG;
          end
          ST_HOLD: begin
            if (r_cnt == '0) begin
              r_state <= ST_OPEN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_OPEN: begin
            if (w_owner_req) begin
              // Owner keeps the display and may change its text live.
              r_msg <= msg_at(w_flat, r_owner);
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_owner <= '0;
              r_msg   <= IDLE_MSG;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.owner   = r_owner;
  assign bus.msg_out = r_msg;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule : hex_display_arbiter
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_display_arbiter
//  Description : Self-checking bench for hex_display_arbiter, N=4,
//                HOLD_CYCLES=8. A vector table covers grant, hold and
//                handover; hand-written sequences cover rotation, live text
//                update, mid-hold reset and urgent preemption
//                (HEX_ARB_PREEMPT_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_arbiter;
  import hex_disp_pkg::*;

  localparam int          N    = 4;
  localparam int          HOLD = 8;
  localparam logic [31:0] IDLE = 32'h46696E63;  // "Finc"
  localparam logic [31:0] M0   = 32'h45525230;  // "ERR0"
  localparam logic [31:0] M1   = 32'h53573031;  // "SW01"
  localparam logic [31:0] M2   = 32'h53353031;  // "S501"
  localparam logic [31:0] M2B  = 32'h53353032;  // "S502"
  localparam logic [31:0] M3   = 32'h4C4F434B;  // "LOCK"

  logic clk;
  logic reset;

  hex_display_arbiter_if #(.N(N)) bus ();

  hex_display_arbiter #(
    .N           (N),
    .HOLD_CYCLES (HOLD),
    .IDLE_MSG    (IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          cyc;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic [31:0] msg;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] mtab [4];
  logic [3:0]  rot_req;
  int          rot_seq [5];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [2:0] o,
                           input logic [31:0] m, input logic b, input logic d);
    check($sformatf("%s.gnt", tag),     32'(bus.gnt),   32'(g));
    check($sformatf("%s.owner", tag),   32'(bus.owner), 32'(o));
    check($sformatf("%s.msg_out", tag), bus.msg_out,    m);
    check($sformatf("%s.busy", tag),    32'(bus.busy),  32'(b));
    check($sformatf("%s.done", tag),    32'(bus.done),  32'(d));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_msgs(input logic [31:0] m2_val);
    bus.msg_in = {M3, m2_val, M1, M0};
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    mtab[0] = M0; mtab[1] = M1; mtab[2] = M2; mtab[3] = M3;

    //        req      cyc gnt      own   msg  busy  done
    tbl[0] = '{4'b0010, 1, 4'b0010, 3'd1, M1,   1'b1, 1'b0};  // grant from idle
    tbl[1] = '{4'b0010, 1, 4'b0010, 3'd1, M1,   1'b1, 1'b0};
    tbl[2] = '{4'b1010, 7, 4'b0010, 3'd1, M1,   1'b1, 1'b0};  // req3 waits out hold
    tbl[3] = '{4'b1010, 1, 4'b1000, 3'd3, M3,   1'b1, 1'b1};  // handover at grant+9
    tbl[4] = '{4'b1010, 1, 4'b1000, 3'd3, M3,   1'b1, 1'b0};  // done is one cycle
    tbl[5] = '{4'b0000, 7, 4'b1000, 3'd3, M3,   1'b1, 1'b0};  // drop doesn't cut hold
    tbl[6] = '{4'b0000, 1, 4'b0000, 3'd0, IDLE, 1'b0, 1'b1};  // back to idle
    tbl[7] = '{4'b0000, 1, 4'b0000, 3'd0, IDLE, 1'b0, 1'b0};

`ifdef HEX_ARB_PREEMPT_EN
    rot_req = 4'b1110;
    rot_seq = '{1, 2, 3, 1, 2};
`else
    rot_req = 4'b1111;
    rot_seq = '{0, 1, 2, 3, 0};
`endif

    // Reset state
    reset   = 1'b1;
    bus.req = '0;
    set_msgs(M2);
    #12;
    check_all("reset", 4'b0000, 3'd0, IDLE, 1'b0, 1'b0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      bus.req = tbl[i].req;
      tick(tbl[i].cyc);
      check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].msg,
                tbl[i].busy, tbl[i].done);
    end

    // Round-robin rotation with pointer wrap
    bus.req = rot_req;
    tick(1);
    check_all("rot0", 4'(1 << rot_seq[0]), 3'(rot_seq[0]), mtab[rot_seq[0]], 1'b1, 1'b0);
    for (int g = 1; g < 5; g++) begin
      tick(8);
      check($sformatf("rot%0d.held", g), 32'(bus.gnt), 32'(1 << rot_seq[g-1]));
      check($sformatf("rot%0d.nodone", g), 32'(bus.done), 32'd0);
      tick(1);
      check_all($sformatf("rot%0d", g), 4'(1 << rot_seq[g]), 3'(rot_seq[g]),
                mtab[rot_seq[g]], 1'b1, 1'b1);
    end

    // Owner 2 alone in OPEN with live text update, then release
    bus.req = '0;
    pulse_reset();
    bus.req = 4'b0100;
    tick(1);
    check_all("live.grant", 4'b0100, 3'd2, M2, 1'b1, 1'b0);
    tick(8);
    check_all("live.open", 4'b0100, 3'd2, M2, 1'b1, 1'b0);
    set_msgs(M2B);
    tick(1);
    check_all("live.update", 4'b0100, 3'd2, M2B, 1'b1, 1'b0);
    bus.req = '0;
    tick(1);
    check_all("live.release", 4'b0000, 3'd0, IDLE, 1'b0, 1'b1);
    set_msgs(M2);

    // Reset mid-hold (counter at 4): immediate, no done pulse, pointer back to 0
    bus.req = 4'b0010;
    tick(1);
    check("midrst.grant", 32'(bus.gnt), 32'(4'b0010));
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check_all("midrst.async", 4'b0000, 3'd0, IDLE, 1'b0, 1'b0);
    tick(1);
    check_all("midrst.held", 4'b0000, 3'd0, IDLE, 1'b0, 1'b0);
    reset   = 1'b0;
    bus.req = 4'b0011;
    tick(1);
    check_all("midrst.ptr", 4'b0001, 3'd0, M0, 1'b1, 1'b0);
    bus.req = '0;
    pulse_reset();

    // Urgent channel while owner 3 holds at counter 6
    bus.req = 4'b1000;
    tick(1);
    check_all("urg.grant3", 4'b1000, 3'd3, M3, 1'b1, 1'b0);
    tick(1);
    bus.req = 4'b1001;
    tick(1);
`ifdef HEX_ARB_PREEMPT_EN
    check_all("urg.preempt", 4'b0001, 3'd0, M0, 1'b1, 1'b1);
`else
    check_all("urg.wait", 4'b1000, 3'd3, M3, 1'b1, 1'b0);
    tick(6);
    check_all("urg.open", 4'b1000, 3'd3, M3, 1'b1, 1'b0);
    tick(1);
    check_all("urg.handover", 4'b0001, 3'd0, M0, 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hex_display_arbiter
`default_nettype wire

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the four-digit seven-segment message path between up to N independent requesters (lock FSM status, switch echo, error reporter, etc.). It selects one owner at a time, round-robin. It guarantees each granted message stays on the display for a minimum hold time. It presents one registered 32-bit ASCII message (4 × 8-bit characters, digit 3 in bits 31:24) to the ASCII-to-seven-segment converter. When no requester is active, it shows a fixed idle message.

## Interface
- N, 4, number of requesters, 2..8
- HOLD_CYCLES, 50_000_000, minimum display cycles per grant, ≥1
- IDLE_MSG, 32'h46696E63 ("Finc"), message shown while no owner
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req  in  N  per-requester level request; held while the requester wants the display
- msg_in  in  N*32  flattened messages; requester i drives bits [i*32+31 : i*32]
- gnt  out  N  one-hot grant, registered; all zero when idle
- owner  out  3  index of current owner; 0 when idle
- msg_out  out  32  registered ASCII message to the display converter
- busy  out  1  high in HOLD or OPEN
- done  out  1  one-cycle pulse in the cycle after a grant ends

## Operation
- Reset values: gnt=0, owner=0, msg_out=IDLE_MSG, busy=0, done=0, state=IDLE, rr pointer=0, hold counter=0.
- States:
  - IDLE
  - HOLD: minimum display time running
  - OPEN: hold expired, owner retained
- Round-robin search starts at the rr pointer and wraps modulo N. On grant to requester i, the pointer becomes (i+1) mod N.
- IDLE:
  - If any req is high: pick the winner, latch its msg_in into msg_out, set gnt/owner, load counter=HOLD_CYCLES-1, go to HOLD.
  - Otherwise msg_out=IDLE_MSG.
- HOLD:
  - msg_out is frozen.
  - Counter decrements each cycle. At 0, go to OPEN.
  - The owner dropping req does not shorten the hold.
- OPEN (evaluated every cycle):
  - Another req high (excluding the owner): regrant to the next requester via round-robin, latch its message, reload the counter, go to HOLD, pulse done.
  - Else if the owner's req is high: stay in OPEN. msg_out re-latches the owner's msg_in every cycle, so the owner can update its text live.
  - Else: go to IDLE, clear gnt, load IDLE_MSG, pulse done.
- Simultaneous events:
  - Owner drop and another requester's rise in the same OPEN cycle: regrant (the regrant rule has priority).
  - A requester's req edge in the same cycle as the HOLD→OPEN transition is seen in the first OPEN cycle.
- Counter width: $clog2(HOLD_CYCLES+1). No wrap-around, because it reloads before underflow.
- Reset mid-operation: all state returns to its reset value immediately. No done pulse is generated.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives gnt, owner, msg_out and busy valid after edge k. They are visible in cycle k+1.
- Display duration: a granted message is displayed for exactly HOLD_CYCLES cycles in HOLD before any regrant is possible. The earliest handover is HOLD_CYCLES+1 cycles after the grant.
- done is asserted for one cycle, in the same cycle the new gnt (or idle) takes effect.
- All outputs are registered. There is no combinational path from req/msg_in to the outputs.

## Configuration
- HEX_ARB_PREEMPT_EN defined:
  - req[0] is an urgent channel (error/alarm).
  - In HOLD or OPEN with owner≠0 and req[0] high, the next edge grants requester 0, latches its message, reloads the counter, and pulses done. The hold is cut short.
  - The rr pointer is not updated by a preemptive grant.
- HEX_ARB_PREEMPT_EN undefined: requester 0 is an ordinary round-robin participant.

## Structure
- Package hex_disp_pkg holds:
  - the arbiter state enum (IDLE, HOLD, OPEN)
  - MSG_W=32 and CHAR_W=8
  - IDLE_MSG default
  - a function extracting message i from the flat bus
- One combinational sub-module, rr_pick: inputs req mask and pointer, outputs one-hot winner and index, with wrap-around search. It is reused for the idle grant and the OPEN regrant.

## Test plan
Each scenario uses N=4 and HOLD_CYCLES=8.

- Reset → gnt=0000, msg_out=0x46696E63, busy=0. Then req=0010 → after 1 edge gnt=0010, owner=1, msg_out=msg_in[63:32].
- Owner 1 holds, req[3] rises at grant+2 → gnt remains 0010 for 8 cycles. At cycle 9 after the grant, gnt=1000 and done pulses once.
- req=1111 continuously → grants rotate 0001→0010→0100→1000→0001, each held 9 cycles. Check the rr pointer wrap.
- Owner 2 alone in OPEN, msg_in[95:64] changes from "S501" to "S502" → msg_out follows the next cycle. Drop req[2] → IDLE_MSG next cycle, done=1.
- Assert reset during HOLD with counter=4 → all outputs return to reset values asynchronously, with no done pulse.
- With HEX_ARB_PREEMPT_EN: owner 3 in HOLD at counter=6, req[0] rises → next edge gnt=0001 and done=1. Without the macro: gnt stays 1000 until the hold expires.
